// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative unsigned 32x32 multiply / 32/32 divide sequencer.
// One shared 32-bit ALU does an add per step for multiply (shift-add) and a
// subtract per step for divide (restoring). The 33rd bit of each operation is
// rebuilt from operand/result sign bits, so the ALU is the only adder here.
// Handshake: start is sampled only while idle; busy is high while iterating;
// done pulses for exactly one cycle when hi/lo first hold the final result.

// Small MIPS-style ALU: and/or/add/sub/slt selected by alucont.
module alu (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  alucont,
   output logic [31:0] result
);

   logic [31:0] b_eff;
   logic [31:0] sum;

   // alucont[2] turns the adder into a subtractor (invert b, carry in 1).
   always_comb begin
      b_eff  = alucont[2] ? ~b : b;
      sum    = a + b_eff + {31'd0, alucont[2]};
      result = 32'd0;
      case (alucont[1:0])
         2'b00:   result = a & b_eff;
         2'b01:   result = a | b_eff;
         2'b10:   result = sum;
         default: result = {31'd0, sum[31]};
      endcase
   end

endmodule

module muldiv_seq (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q,   cnt_d;
   logic [31:0] opnd_q,  opnd_d;
   logic        op_r_q,  op_r_d;
   logic [31:0] hi_q,    hi_d;
   logic [31:0] lo_q,    lo_d;
   logic        done_q,  done_d;

   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_cont;
   logic [31:0] alu_y;

   logic [31:0] shift_r;
   logic        top;
   logic        carry;
   logic        ge;

   alu u_alu (
      .a       (alu_a),
      .b       (alu_b),
      .alucont (alu_cont),
      .result  (alu_y)
   );

   // ALU operand steering and 33rd-bit reconstruction for both step types.
   always_comb begin
      alu_cont = op_r_q ? 3'b110 : 3'b010;
      shift_r  = {hi_q[30:0], lo_q[31]};
      top      = hi_q[31];
      alu_a    = op_r_q ? shift_r : hi_q;
      alu_b    = opnd_q;
      // Multiply: carry out of hi + opnd.
      carry    = (hi_q[31] & opnd_q[31]) |
                 ((hi_q[31] | opnd_q[31]) & ~alu_y[31]);
      // Divide: {top, shift_r} >= opnd, i.e. no borrow out of the subtract.
      ge       = top |
                 (shift_r[31] & ~opnd_q[31]) |
                 (~(shift_r[31] ^ opnd_q[31]) & ~alu_y[31]);
   end

   // Next-state, iteration step and done pulse; everything holds by default.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      opnd_d  = opnd_q;
      op_r_d  = op_r_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               opnd_d  = b;
               op_r_d  = op;
               hi_d    = 32'd0;
               lo_d    = a;
               cnt_d   = 5'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (!op_r_q) begin
               if (lo_q[0]) begin
                  {hi_d, lo_d} = {carry, alu_y, lo_q[31:1]};
               end else begin
                  {hi_d, lo_d} = {1'b0, hi_q, lo_q[31:1]};
               end
            end else begin
               if (ge) begin
                  hi_d = alu_y;
                  lo_d = {lo_q[30:0], 1'b1};
               end else begin
                  hi_d = shift_r;
                  lo_d = {lo_q[30:0], 1'b0};
               end
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register; reset aborts any operation without a done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         opnd_q  <= 32'd0;
         op_r_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         opnd_q  <= opnd_d;
         op_r_q  <= op_r_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      busy = (state_q == RUN);
      done = done_q;
      hi   = hi_q;
      lo   = lo_q;
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed and random operations,
// start-during-run, back-to-back start in the done cycle, reset mid-run.
module tb_muldiv_seq;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op_i;
   logic [31:0] a_i;
   logic [31:0] b_i;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks   = 0;
   int failures = 0;

   logic [63:0] exp_q[$];

   muldiv_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op_i),
      .a     (a_i),
      .b     (b_i),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: {hi,lo} for a given operation.
   function automatic logic [63:0] model(input logic op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] r;
      if (!op) begin
         r = {32'd0, a} * {32'd0, b};
      end else if (b == 32'd0) begin
         r = {a, 32'hFFFF_FFFF};
      end else begin
         r = {a % b, a / b};
      end
      return r;
   endfunction

   // Driver: present a start for one edge, optionally record the expectation.
   // Returns #1 after the sampling edge.
   task automatic start_op(input logic op, input logic [31:0] a, input logic [31:0] b,
                           input bit push);
      start = 1'b1;
      op_i  = op;
      a_i   = a;
      b_i   = b;
      if (push) exp_q.push_back(model(op, a, b));
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Wait for done (bounded), check latency, busy length and the result.
   // inject_at >= 0 drives a stray start with other operands mid-run.
   task automatic wait_and_check(input string tag, input int inject_at);
      int cyc  = 0;
      int bcnt = 0;
      bit seen = 0;
      logic [63:0] exp;
      while (cyc < 100) begin
         if (done) begin
            seen = 1;
            break;
         end
         if (busy) bcnt++;
         if (cyc == inject_at) begin
            start = 1'b1;
            op_i  = $urandom_range(0, 1);
            a_i   = $urandom;
            b_i   = $urandom;
         end else begin
            start = 1'b0;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
      check({tag, "_latency"}, 64'(cyc), 64'd32);
      check({tag, "_busy_cycles"}, 64'(bcnt), 64'd32);
      check({tag, "_busy_low_at_done"}, {63'd0, busy}, 64'd0);
      if (exp_q.size() == 0) begin
         check({tag, "_queue_empty"}, 64'd1, 64'd0);
      end else begin
         exp = exp_q.pop_front();
         check({tag, "_result"}, {hi, lo}, exp);
      end
   endtask

   task automatic check_done_drops(input string tag);
      @(posedge clk);
      #1;
      check({tag, "_done_pulse_1cyc"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      logic [63:0] last;
      int done_cnt;
      reset = 1'b1;
      start = 1'b0;
      op_i  = 1'b0;
      a_i   = 32'd0;
      b_i   = 32'd0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_busy", {63'd0, busy}, 64'd0);
      check("reset_done", {63'd0, done}, 64'd0);
      check("reset_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Directed cases
      start_op(1'b0, 32'd7, 32'd6, 1);
      wait_and_check("mul_7x6", -1);
      check("mul_7x6_lo", {32'd0, lo}, 64'd42);
      check_done_drops("mul_7x6");

      start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
      wait_and_check("mul_max", -1);
      check("mul_max_const", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
      check_done_drops("mul_max");

      start_op(1'b1, 32'd100, 32'd7, 1);
      wait_and_check("div_100_7", -1);
      check("div_100_7_const", {hi, lo}, {32'd2, 32'd14});

      start_op(1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 1);
      wait_and_check("div_top", -1);
      check("div_top_const", {hi, lo}, {32'h7FFF_FFFE, 32'd1});

      start_op(1'b1, 32'h1234_5678, 32'd0, 1);
      wait_and_check("div_zero", -1);
      check("div_zero_const", {hi, lo}, {32'h1234_5678, 32'hFFFF_FFFF});

      // Result held while idle
      last = {hi, lo};
      repeat (6) @(posedge clk);
      #1;
      check("idle_hold", {hi, lo}, last);
      check("idle_busy", {63'd0, busy}, 64'd0);

      // Stray start during run is ignored
      start_op(1'b0, 32'd1234, 32'd5678, 1);
      wait_and_check("start_ignored", 5);

      // Back-to-back: new start in the done cycle
      start_op(1'b1, 32'd1000, 32'd33, 1);
      wait_and_check("b2b_first", -1);
      start_op(1'b0, 32'hDEAD_BEEF, 32'h0000_1003, 1);
      wait_and_check("b2b_second", -1);

      // Random operations
      for (int i = 0; i < 10; i++) begin
         logic        rop;
         logic [31:0] ra, rb;
         rop = $urandom_range(0, 1);
         ra  = $urandom;
         case ($urandom_range(0, 2))
            0:       rb = $urandom_range(1, 20);
            1:       rb = $urandom;
            default: rb = ra >> $urandom_range(0, 31);
         endcase
         @(negedge clk);
         start_op(rop, ra, rb, 1);
         wait_and_check($sformatf("rand%0d", i), -1);
      end

      // Reset mid-operation
      @(negedge clk);
      start_op(1'b0, 32'hFFFF_0001, 32'h0F0F_F0F0, 0);
      repeat (10) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("rst_mid_busy", {63'd0, busy}, 64'd0);
      check("rst_mid_done", {63'd0, done}, 64'd0);
      check("rst_mid_hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      done_cnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk);
         #1;
         if (done) done_cnt++;
      end
      check("rst_no_done", 64'(done_cnt), 64'd0);
      start_op(1'b0, 32'd3, 32'd5, 1);
      wait_and_check("mul_3x5", -1);
      check("mul_3x5_lo", {32'd0, lo}, 64'd15);

      check("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time bound
   initial begin
      #1_000_000;
      failures++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
